// File: rtl/trade_pkg.sv
// rtl/trade_pkg.sv - shared types for the multi-asset trade engine
package trade_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PENDING  = 2'd1,
        COOLDOWN = 2'd2
    } chan_state_e;

    typedef enum logic {
        BUY  = 1'b0,
        SELL = 1'b1
    } side_e;

    // Field widths of the order record for the default build (4 assets, 64-bit prices)
    localparam int ORDER_ASSET_W = 2;
    localparam int ORDER_PRICE_W = 64;

    typedef struct packed {
        logic [ORDER_ASSET_W-1:0] asset;
        side_e                    side;
        logic [ORDER_PRICE_W-1:0] price;
    } order_t;

endpackage

// File: rtl/trade_channel.sv
// rtl/trade_channel.sv - one price channel: thresholds, crossing compare, FSM, cooldown
module trade_channel
    import trade_pkg::*;
#(
    parameter int PRICE_W      = 64,
    parameter int COOLDOWN_CYC = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               price_valid,
    input  logic [PRICE_W-1:0] price,
    input  logic               cfg_we,
    input  logic [PRICE_W-1:0] cfg_buy_thr,
    input  logic [PRICE_W-1:0] cfg_sell_thr,
    input  logic               grant,
    output logic               pending,
    output side_e              pend_side,
    output logic [PRICE_W-1:0] pend_price,
    output logic               drop
);

    localparam int CNT_W = (COOLDOWN_CYC > 0) ? $clog2(COOLDOWN_CYC + 1) : 1;

    logic [PRICE_W-1:0] buy_thr;
    logic [PRICE_W-1:0] sell_thr;
    logic               is_buy;
    logic               is_sell;
    chan_state_e        state;
    logic [CNT_W-1:0]   cnt;

    // Threshold registers; reset values make both compares impossible (channel disabled)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buy_thr  <= '0;
            sell_thr <= '1;
        end else if (cfg_we) begin
            buy_thr  <= cfg_buy_thr;
            sell_thr <= cfg_sell_thr;
        end
    end

    // Strict crossing compares against the currently programmed thresholds
    always_comb begin
        is_buy  = (price < buy_thr);
        is_sell = (price > sell_thr);
    end

    // Channel FSM: capture a crossing, wait for the arbiter, then sit out the cooldown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            pend_side  <= BUY;
            pend_price <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (price_valid && (is_buy || is_sell)) begin
                        state      <= PENDING;
                        pend_price <= price;
                        pend_side  <= is_buy ? BUY : SELL;
                    end
                end
                PENDING: begin
                    if (grant) begin
                        if (COOLDOWN_CYC == 0) begin
                            state <= IDLE;
                        end else begin
                            state <= COOLDOWN;
                            cnt   <= CNT_W'(COOLDOWN_CYC);
                        end
                    end
                end
                COOLDOWN: begin
                    if (cnt <= CNT_W'(1)) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pending = (state == PENDING);
    // Only samples lost while waiting for a grant are reported; cooldown discards are silent
    assign drop    = price_valid && (state == PENDING);

endmodule

// File: rtl/multi_asset_trade_engine.sv
// rtl/multi_asset_trade_engine.sv - N price channels, round-robin arbiter, registered order stream
module multi_asset_trade_engine
    import trade_pkg::*;
#(
    parameter int NUM_ASSETS   = 4,
    parameter int PRICE_W      = 64,
    parameter int COOLDOWN_CYC = 8,
    parameter int DROP_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_ASSETS-1:0]         price_valid,
    input  logic [NUM_ASSETS*PRICE_W-1:0] price,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_ASSETS)-1:0] cfg_addr,
    input  logic [PRICE_W-1:0]            cfg_buy_thr,
    input  logic [PRICE_W-1:0]            cfg_sell_thr,
    output logic                          order_valid,
    input  logic                          order_ready,
    output logic [$clog2(NUM_ASSETS)-1:0] order_asset,
    output logic                          order_side,
    output logic [PRICE_W-1:0]            order_price,
    output logic [DROP_W-1:0]             drop_count
);

    localparam int AW = $clog2(NUM_ASSETS);

    logic [NUM_ASSETS-1:0] ch_cfg_we;
    logic [NUM_ASSETS-1:0] ch_pending;
    logic [NUM_ASSETS-1:0] ch_drop;
    logic [NUM_ASSETS-1:0] ch_grant;
    side_e                 ch_side  [NUM_ASSETS];
    logic [PRICE_W-1:0]    ch_price [NUM_ASSETS];

    logic                  loadable;
    logic                  found;
    int                    gidx;
    logic [AW-1:0]         rr_ptr;
    int                    ndrop;
    logic [DROP_W:0]       drop_sum;
    logic [DROP_W-1:0]     drop_next;

    for (genvar i = 0; i < NUM_ASSETS; i++) begin : g_chan
        // Out-of-range addresses match no channel, so such writes fall on the floor
        assign ch_cfg_we[i] = cfg_we && (int'(cfg_addr) == i);

        trade_channel #(
            .PRICE_W      (PRICE_W),
            .COOLDOWN_CYC (COOLDOWN_CYC)
        ) u_chan (
            .clk          (clk),
            .rst_n        (rst_n),
            .price_valid  (price_valid[i]),
            .price        (price[i*PRICE_W +: PRICE_W]),
            .cfg_we       (ch_cfg_we[i]),
            .cfg_buy_thr  (cfg_buy_thr),
            .cfg_sell_thr (cfg_sell_thr),
            .grant        (ch_grant[i]),
            .pending      (ch_pending[i]),
            .pend_side    (ch_side[i]),
            .pend_price   (ch_price[i]),
            .drop         (ch_drop[i])
        );
    end

    // Round-robin search: first pending channel at or after rr_ptr, granted only when the output can load
    always_comb begin
        found    = 1'b0;
        gidx     = 0;
        ch_grant = '0;
        loadable = !order_valid || order_ready;
        for (int k = 0; k < NUM_ASSETS; k++) begin
            if (!found && ch_pending[(int'(rr_ptr) + k) % NUM_ASSETS]) begin
                found = 1'b1;
                gidx  = (int'(rr_ptr) + k) % NUM_ASSETS;
            end
        end
        if (loadable && found) begin
            ch_grant[gidx] = 1'b1;
        end
    end

    // Output register: reload on acceptance or when empty; hold everything under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            order_valid <= 1'b0;
            order_asset <= '0;
            order_side  <= 1'b0;
            order_price <= '0;
            rr_ptr      <= '0;
        end else if (loadable) begin
            order_valid <= found;
            if (found) begin
                order_asset <= AW'(gidx);
                order_side  <= ch_side[gidx];
                order_price <= ch_price[gidx];
                rr_ptr      <= AW'((gidx + 1) % NUM_ASSETS);
            end
        end
    end

    // Several channels can drop in one cycle; add them all and clamp at all-ones
    always_comb begin
        ndrop = 0;
        for (int k = 0; k < NUM_ASSETS; k++) begin
            ndrop = ndrop + int'(ch_drop[k]);
        end
        drop_sum  = {1'b0, drop_count} + (DROP_W+1)'(ndrop);
        drop_next = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

    // Saturating drop counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else begin
            drop_count <= drop_next;
        end
    end

endmodule

// File: tb/tb_multi_asset_trade_engine.sv
// tb/tb_multi_asset_trade_engine.sv - directed self-checking bench for multi_asset_trade_engine
module tb_multi_asset_trade_engine;
    import trade_pkg::*;

    localparam int N  = 4;
    localparam int PW = 64;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    price_valid;
    logic [N*PW-1:0] price;
    logic            cfg_we;
    logic [1:0]      cfg_addr;
    logic [PW-1:0]   cfg_buy_thr;
    logic [PW-1:0]   cfg_sell_thr;
    logic            order_valid;
    logic            order_ready;
    logic [1:0]      order_asset;
    logic            order_side;
    logic [PW-1:0]   order_price;
    logic [15:0]     drop_count;

    int checks = 0;
    int errors = 0;

    multi_asset_trade_engine #(
        .NUM_ASSETS   (N),
        .PRICE_W      (PW),
        .COOLDOWN_CYC (8),
        .DROP_W       (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .price_valid  (price_valid),
        .price        (price),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_buy_thr  (cfg_buy_thr),
        .cfg_sell_thr (cfg_sell_thr),
        .order_valid  (order_valid),
        .order_ready  (order_ready),
        .order_asset  (order_asset),
        .order_side   (order_side),
        .order_price  (order_price),
        .drop_count   (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_order(input string tag, input logic [1:0] a, input side_e s, input logic [63:0] p);
        order_t e;
        e.asset = a;
        e.side  = s;
        e.price = p;
        chk({tag, ".valid"}, 64'(order_valid), 64'd1);
        chk({tag, ".asset"}, 64'(order_asset), 64'(e.asset));
        chk({tag, ".side"},  64'(order_side),  64'(e.side));
        chk({tag, ".price"}, order_price, e.price);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        price_valid = '0;
        cfg_we      = 1'b0;
    endtask

    task automatic set_sample(input int ch, input logic [63:0] v);
        price_valid[ch]       = 1'b1;
        price[ch*PW +: PW]    = v;
    endtask

    task automatic sample(input int ch, input logic [63:0] v);
        set_sample(ch, v);
        tick();
        clear_inputs();
    endtask

    task automatic cfg(input logic [1:0] a, input logic [63:0] b, input logic [63:0] s);
        cfg_we       = 1'b1;
        cfg_addr     = a;
        cfg_buy_thr  = b;
        cfg_sell_thr = s;
        tick();
        clear_inputs();
    endtask

    initial begin
        rst_n        = 1'b0;
        price_valid  = '0;
        price        = '0;
        cfg_we       = 1'b0;
        cfg_addr     = '0;
        cfg_buy_thr  = '0;
        cfg_sell_thr = '0;
        order_ready  = 1'b1;
        repeat (2) tick();
        chk("rst.valid", 64'(order_valid), 64'd0);
        chk("rst.asset", 64'(order_asset), 64'd0);
        chk("rst.side",  64'(order_side),  64'd0);
        chk("rst.price", order_price, 64'd0);
        chk("rst.drop",  64'(drop_count), 64'd0);
        rst_n = 1'b1;
        tick();

        // Thresholds disabled out of reset
        sample(0, 64'd100);
        repeat (3) tick();
        chk("disabled.valid", 64'(order_valid), 64'd0);

        // ch0 buy below 200
        cfg(2'd0, 64'd200, '1);
        sample(0, 64'd150);
        chk("buy.lat", 64'(order_valid), 64'd0);
        tick();
        chk_order("buy", 2'd0, BUY, 64'd150);
        tick();
        chk("buy.release", 64'(order_valid), 64'd0);

        // ch1 sell strictly above 1000
        cfg(2'd1, 64'd0, 64'd1000);
        sample(1, 64'd1001);
        tick();
        chk_order("sell", 2'd1, SELL, 64'd1001);
        sample(1, 64'd1000);
        repeat (3) tick();
        chk("sell.strict", 64'(order_valid), 64'd0);

        // A sample in the same cycle as its channel's cfg write sees the old thresholds
        cfg_we       = 1'b1;
        cfg_addr     = 2'd2;
        cfg_buy_thr  = 64'd500;
        cfg_sell_thr = '1;
        set_sample(2, 64'd400);
        tick();
        clear_inputs();
        repeat (3) tick();
        chk("cfgsame.valid", 64'(order_valid), 64'd0);

        // ch3 single order moves rr_ptr back to 0
        cfg(2'd3, 64'd500, '1);
        sample(3, 64'd300);
        tick();
        chk_order("ch3", 2'd3, BUY, 64'd300);
        repeat (12) tick();

        // Three simultaneous crossings, issued back to back
        set_sample(0, 64'd150);
        set_sample(2, 64'd400);
        set_sample(3, 64'd300);
        tick();
        clear_inputs();
        tick();
        chk_order("rr1.a", 2'd0, BUY, 64'd150);
        tick();
        chk_order("rr1.b", 2'd2, BUY, 64'd400);
        tick();
        chk_order("rr1.c", 2'd3, BUY, 64'd300);
        tick();
        chk("rr1.end", 64'(order_valid), 64'd0);
        repeat (12) tick();

        set_sample(0, 64'd151);
        set_sample(2, 64'd401);
        set_sample(3, 64'd301);
        tick();
        clear_inputs();
        tick();
        chk_order("rr2.a", 2'd0, BUY, 64'd151);
        tick();
        chk_order("rr2.b", 2'd2, BUY, 64'd401);
        tick();
        chk_order("rr2.c", 2'd3, BUY, 64'd301);
        repeat (12) tick();

        // Backpressure: held order stays stable, extra samples on a pending channel are counted
        order_ready = 1'b0;
        set_sample(0, 64'd120);
        tick();
        clear_inputs();
        set_sample(2, 64'd410);
        tick();
        clear_inputs();
        chk_order("bp.load", 2'd0, BUY, 64'd120);
        set_sample(2, 64'd420);
        tick();
        clear_inputs();
        set_sample(2, 64'd430);
        tick();
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_order("bp.hold", 2'd0, BUY, 64'd120);
        end
        chk("bp.drop", 64'(drop_count), 64'd2);
        order_ready = 1'b1;
        tick();
        chk_order("bp.next", 2'd2, BUY, 64'd410);

        // Cooldown on ch2, granted at the edge just passed (G)
        tick();
        chk("cd.release", 64'(order_valid), 64'd0);
        repeat (2) tick();
        sample(2, 64'd405);
        tick();
        chk("cd.g4.valid", 64'(order_valid), 64'd0);
        chk("cd.g4.drop", 64'(drop_count), 64'd2);
        repeat (2) tick();
        set_sample(2, 64'd440);
        tick();
        clear_inputs();
        set_sample(2, 64'd450);
        tick();
        clear_inputs();
        chk("cd.g8.valid", 64'(order_valid), 64'd0);
        tick();
        chk_order("cd.g9", 2'd2, BUY, 64'd450);
        chk("cd.drop", 64'(drop_count), 64'd2);
        repeat (12) tick();

        // Asynchronous reset while an order is held
        order_ready = 1'b0;
        sample(0, 64'd130);
        tick();
        chk_order("rst2.held", 2'd0, BUY, 64'd130);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2.valid", 64'(order_valid), 64'd0);
        chk("rst2.drop", 64'(drop_count), 64'd0);
        tick();
        rst_n       = 1'b1;
        order_ready = 1'b1;
        tick();
        sample(0, 64'd130);
        repeat (3) tick();
        chk("rst2.disabled", 64'(order_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
